// File: rtl/hamming_top.sv
// ---------------------------------------------------------------------------
// hamming_top
//
// Purpose:
//   Reads four asynchronous switches, synchronizes them, encodes the nibble
//   as a Hamming(7,4) codeword, decodes it again with single-bit correction,
//   and shows the result on four active-low LEDs and a two-digit decimal
//   7-segment display (tens digit is 0 or 1).
//
//   Pipeline (one register per stage, all on the rising clk edge):
//     stage 1 : first synchronizer flop for each switch
//     stage 2 : second synchronizer flop, forms data word D[3:0]
//     stage 3 : Hamming(7,4) codeword C[1:7]
//     stage 4 : syndrome, correction, data extraction, display registers
//   A switch change stable before edge N reaches the outputs after edge N+3.
//
// Configuration:
//   HAMMING_ERR_INJECT_EN - when defined, a free-running 3-bit counter k
//   flips channel bit R[k] (k != 0) between stage 3 and stage 4. The
//   decoder corrects it, so the outputs match the plain build exactly.
//   When undefined the counter does not exist and R = C.
//
// Ports:
//   clk                     in   system clock, sole clock domain
//   rst                     in   synchronous active-high reset
//   ag, bg, cg, dg          in   switch inputs, data bits d0 (ag) .. d3 (dg)
//   led[3:0]                out  active-low image of decoded data
//   au..gu                  out  units-digit segments a..g, active-high
//   ad..gd                  out  tens-digit segments a..g, active-high
// ---------------------------------------------------------------------------
module hamming_top (
  input  logic       clk,
  input  logic       rst,
  input  logic       ag,
  input  logic       bg,
  input  logic       cg,
  input  logic       dg,
  output logic [3:0] led,
  output logic       au,
  output logic       bu,
  output logic       cu,
  output logic       du,
  output logic       eu,
  output logic       fu,
  output logic       gu,
  output logic       ad,
  output logic       bd,
  output logic       cd,
  output logic       dd,
  output logic       ed,
  output logic       fd,
  output logic       gd
);

  // Segment pattern for the digit zero; also the reset image of both digits.
  localparam logic [6:0] SEG_ZERO = 7'b1111110;

  // Pipeline state
  logic [3:0] sync_meta;   // stage 1
  logic [3:0] data;        // stage 2, D[3:0]
  logic [7:1] code;        // stage 3, C[1:7]
  logic [3:0] led_reg;     // stage 4
  logic [6:0] units_reg;   // stage 4, bit 6 = segment a
  logic [6:0] tens_reg;    // stage 4, bit 6 = segment a

  // Decode-stage combinational signals
  logic [7:1] chan;        // channel word R
  logic [2:0] syndrome;    // {s4, s2, s1}
  logic [3:0] q_dec;       // corrected data Q
  logic [3:0] units_val;
  logic       tens_val;
  logic [6:0] units_seg;
  logic [6:0] tens_seg;

  // Hamming(7,4) encoder; bit index equals codeword position 1..7.
  function automatic logic [7:1] hamming_encode(input logic [3:0] d);
    logic [7:1] c;
    c[1] = d[0] ^ d[1] ^ d[3];
    c[2] = d[0] ^ d[2] ^ d[3];
    c[3] = d[0];
    c[4] = d[1] ^ d[2] ^ d[3];
    c[5] = d[1];
    c[6] = d[2];
    c[7] = d[3];
    return c;
  endfunction

  // Decimal digit to segments abcdefg (bit 6 = a). Values above 9 never
  // reach this function in normal operation; they blank the digit.
  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  // Stages 1 and 2: two-flop synchronizer for all four switches.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta <= '0;
      data      <= '0;
    end else begin
      sync_meta <= {dg, cg, bg, ag};
      data      <= sync_meta;
    end
  end

  // Stage 3: register the codeword.
  always_ff @(posedge clk) begin
    if (rst) begin
      code <= '0;
    end else begin
      code <= hamming_encode(data);
    end
  end

`ifdef HAMMING_ERR_INJECT_EN
  logic [2:0] err_cnt;

  // Free-running error position; keeps counting even while D is steady so
  // every codeword position gets exercised.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else begin
      err_cnt <= err_cnt + 3'd1;
    end
  end

  // Flip channel bit R[k]; k = 0 means no error this cycle.
  always_comb begin
    chan = code;
    for (int i = 1; i < 8; i++) begin
      if (err_cnt == 3'(i)) begin
        chan[i] = ~code[i];
      end
    end
  end
`else
  assign chan = code;
`endif

  // Syndrome: each bit checks the positions whose index has that bit set,
  // so a nonzero syndrome is the position of the single flipped bit.
  always_comb begin
    syndrome[0] = chan[1] ^ chan[3] ^ chan[5] ^ chan[7];
    syndrome[1] = chan[2] ^ chan[3] ^ chan[6] ^ chan[7];
    syndrome[2] = chan[4] ^ chan[5] ^ chan[6] ^ chan[7];
  end

  // Correction is only needed on the data positions 3, 5, 6, 7; a flipped
  // parity bit needs no action on the extracted data.
  always_comb begin
    q_dec[0] = chan[3] ^ (syndrome == 3'd3);
    q_dec[1] = chan[5] ^ (syndrome == 3'd5);
    q_dec[2] = chan[6] ^ (syndrome == 3'd6);
    q_dec[3] = chan[7] ^ (syndrome == 3'd7);
  end

  // Split Q into a tens digit (0 or 1) and a units digit.
  always_comb begin
    tens_val  = 1'b0;
    units_val = q_dec;
    if (q_dec >= 4'd10) begin
      tens_val  = 1'b1;
      units_val = q_dec - 4'd10;
    end
    units_seg = seg7(units_val);
    tens_seg  = tens_val ? seg7(4'd1) : seg7(4'd0);
  end

  // Stage 4: register the display images so every output comes from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_reg   <= 4'b1111;
      units_reg <= SEG_ZERO;
      tens_reg  <= SEG_ZERO;
    end else begin
      led_reg   <= ~q_dec;
      units_reg <= units_seg;
      tens_reg  <= tens_seg;
    end
  end

  assign led = led_reg;
  assign {au, bu, cu, du, eu, fu, gu} = units_reg;
  assign {ad, bd, cd, dd, ed, fd, gd} = tens_reg;

endmodule

// File: tb/tb_hamming_top.sv
// ---------------------------------------------------------------------------
// tb_hamming_top
//
// Purpose:
//   Self-checking bench for hamming_top. The stimulus process drives one
//   switch value (and rst) per clock and pushes the display expected after
//   that edge into a scoreboard queue. The expectation comes from a
//   behavioural model: the value shown after edge t is the switch value
//   applied three edges earlier, or zero if rst was seen at any edge in that
//   window; the display is then ~d on the LEDs and d/10, d%10 as decimal
//   digits. A separate monitor pops one entry on every falling edge and
//   compares it with the DUT outputs.
//
//   If HAMMING_ERR_INJECT_EN is defined, the decode-stage syndrome is also
//   checked against an independent count of edges since reset.
// ---------------------------------------------------------------------------
module tb_hamming_top;

  logic       clk = 1'b0;
  logic       rst;
  logic       ag, bg, cg, dg;
  logic [3:0] led;
  logic       au, bu, cu, du, eu, fu, gu;
  logic       ad, bd, cd, dd, ed, fd, gd;

  typedef struct packed {
    logic [3:0] led;
    logic [6:0] units;
    logic [6:0] tens;
    logic [3:0] shown;
  } exp_t;

  exp_t       sb_q[$];
  logic [3:0] hist_d[$];
  bit         hist_r[$];

  int tests_run = 0;
  int tests_failed = 0;

  logic [6:0] seg_tab [10] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
    7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
  };

  hamming_top dut (
    .clk(clk), .rst(rst),
    .ag(ag), .bg(bg), .cg(cg), .dg(dg),
    .led(led),
    .au(au), .bu(bu), .cu(cu), .du(du), .eu(eu), .fu(fu), .gu(gu),
    .ad(ad), .bd(bd), .cd(cd), .dd(dd), .ed(ed), .fd(fd), .gd(gd)
  );

  always #5 clk = ~clk;

  // Drive one value for the coming edge and queue what must be displayed
  // right after that edge.
  task automatic applyStimulus(input logic [3:0] d, input bit r);
    int   n;
    bit   cleared;
    exp_t e;
    logic [3:0] shown;
    {dg, cg, bg, ag} = d;
    rst = r;
    hist_d.push_back(d);
    hist_r.push_back(r);
    n = hist_d.size() - 1;
    cleared = 1'b0;
    for (int j = n - 3; j <= n; j++) begin
      if (j < 0) cleared = 1'b1;
      else if (hist_r[j]) cleared = 1'b1;
    end
    shown = 4'd0;
    if (!cleared) shown = hist_d[n - 3];
    e.shown = shown;
    e.led   = ~shown;
    e.units = seg_tab[shown % 10];
    e.tens  = seg_tab[shown / 10];
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input exp_t e);
    logic [6:0] units_act;
    logic [6:0] tens_act;
    units_act = {au, bu, cu, du, eu, fu, gu};
    tens_act  = {ad, bd, cd, dd, ed, fd, gd};
    tests_run++;
    if (led !== e.led) begin
      tests_failed++;
      $display("[TB] FAIL led (value %0d) at %0t: got %b expected %b", e.shown, $time, led, e.led);
    end
    tests_run++;
    if (units_act !== e.units) begin
      tests_failed++;
      $display("[TB] FAIL units (value %0d) at %0t: got %b expected %b", e.shown, $time, units_act, e.units);
    end
    tests_run++;
    if (tens_act !== e.tens) begin
      tests_failed++;
      $display("[TB] FAIL tens (value %0d) at %0t: got %b expected %b", e.shown, $time, tens_act, e.tens);
    end
  endtask

  // Monitor: one expectation per clock, checked half a cycle after the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checkOutput(e);
      end
    end
  end

`ifdef HAMMING_ERR_INJECT_EN
  logic [2:0] model_k = '0;
  bit         k_started = 1'b0;

  always @(posedge clk) begin
    model_k   <= rst ? 3'd0 : model_k + 3'd1;
    k_started <= 1'b1;
  end

  always @(negedge clk) begin
    if (k_started) begin
      tests_run++;
      if (dut.syndrome !== model_k) begin
        tests_failed++;
        $display("[TB] FAIL syndrome at %0t: got %0d expected %0d", $time, dut.syndrome, model_k);
      end
    end
  end
`endif

  initial begin
    // Reset, then hold zero.
    applyStimulus(4'd0, 1'b1);
    applyStimulus(4'd0, 1'b1);
    repeat (6) applyStimulus(4'd0, 1'b0);

    // One-hot walk ag, bg, cg, dg.
    for (int i = 0; i < 4; i++) begin
      repeat (10) applyStimulus(4'(1 << i), 1'b0);
    end

    // 3, 7, 15: exercises the tens digit.
    repeat (6) applyStimulus(4'd3, 1'b0);
    repeat (6) applyStimulus(4'd7, 1'b0);
    repeat (6) applyStimulus(4'd15, 1'b0);

    // Single step 0 -> 1 for latency.
    repeat (5) applyStimulus(4'd0, 1'b0);
    repeat (5) applyStimulus(4'd1, 1'b0);

    // Reset with a value in flight: 9 must never be shown.
    repeat (4) applyStimulus(4'd0, 1'b0);
    applyStimulus(4'd9, 1'b0);
    applyStimulus(4'd0, 1'b1);
    repeat (5) applyStimulus(4'd0, 1'b0);

    // Reset arriving two stages after a change.
    repeat (5) applyStimulus(4'd12, 1'b0);
    applyStimulus(4'd6, 1'b0);
    applyStimulus(4'd6, 1'b0);
    applyStimulus(4'd6, 1'b1);
    repeat (5) applyStimulus(4'd6, 1'b0);

    // Sweep all 16 values, each held 8 cycles.
    for (int v = 0; v < 16; v++) begin
      repeat (8) applyStimulus(4'(v), 1'b0);
    end

    // Random values every cycle with occasional resets.
    for (int i = 0; i < 200; i++) begin
      applyStimulus(4'($urandom_range(15)), ($urandom_range(31) == 0));
    end
    repeat (4) applyStimulus(4'($urandom_range(15)), 1'b0);

    repeat (2) @(negedge clk);
    #1;
    tests_run++;
    if (sb_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL scoreboard drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/hamming_top.md
HAMMING_TOP -- requirements
Module: hamming_top

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; all state updates on the rising clk edge.
REQ-002 clk  input  1  system clock; sole clock domain.
REQ-003 rst  input  1  synchronous active-high reset, sampled on rising clk.
REQ-004 ag, bg, cg, dg  input  1 each  asynchronous switch inputs, data bits d0 (ag, LSB) .. d3 (dg, MSB).
REQ-005 led  output  4  active-low LED image of decoded data; led[i] = ~d[i].
REQ-006 au, bu, cu, du, eu, fu, gu  output  1 each  units-digit 7-segment segments a..g, active-high.
REQ-007 ad, bd, cd, dd, ed, fd, gd  output  1 each  tens-digit 7-segment segments a..g, active-high.
REQ-008 All outputs SHALL be driven directly from flops.

Function
REQ-009 Each switch input SHALL pass through a 2-flop synchronizer; the stage-2 outputs form data word D[3:0].
REQ-010 Stage 3 SHALL register Hamming(7,4) codeword C[1:7] = {p1, p2, D0, p4, D1, D2, D3}, with p1 = D0^D1^D3, p2 = D0^D2^D3, p4 = D1^D2^D3.
REQ-011 The channel word R SHALL equal C, modified only as in REQ-020.
REQ-012 Stage 4 SHALL compute syndrome S = {s4, s2, s1}: s1 = R1^R3^R5^R7, s2 = R2^R3^R6^R7, s4 = R4^R5^R6^R7.
REQ-013 When S != 0, stage 4 SHALL invert bit R[S] before extracting the data Q = {R7, R6, R5, R3}.
REQ-014 Stage 4 SHALL register Q and drive led, units and tens from it.
REQ-015 Display: Q in 0..9 -> tens shows 0, units shows Q; Q in 10..15 -> tens shows 1, units shows Q-10.
REQ-016 Segment patterns, abcdefg: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
REQ-017 Latency: a switch change stable before edge N SHALL appear on all outputs after edge N+3 (4 register stages); no output glitches between updates.
REQ-018 Switch changes on consecutive cycles SHALL each propagate in order; no value is dropped or held.

Reset
REQ-019 While rst = 1 at a clock edge, all synchronizer, codeword and output registers SHALL clear to the D = 0 state: led = 1111, units = 1111110, tens = 1111110, C = 0. Reset applied mid-pipeline SHALL discard all in-flight values.

Configuration
REQ-020 Macro HAMMING_ERR_INJECT_EN:
  - Defined: a 3-bit counter (reset 0) SHALL cycle 0..7, wrapping 7 -> 0, each clk. When the count k != 0, bit R[k] SHALL be inverted. The counter SHALL still advance when D is unchanged.
  - Undefined: the counter SHALL be absent and R = C.
  - In both builds, outputs SHALL be identical for identical inputs.

Verification
REQ-021 rst for 2 cycles, then hold inputs 0 -> led = 1111, tens = 1111110, units = 1111110.
REQ-022 One-hot walk ag, bg, cg, dg, each held 10 cycles -> after 4 cycles each: led = 1110/1101/1011/0111, units = 1/2/4/8 pattern, tens = 0.
REQ-023 dg, cg, bg, ag = 0011 then 0111 then 1111 -> units show 3, 7, 5; tens show 0, 0, 1 (1 = 0110000); led = 1100, 1000, 0000.
REQ-024 Step the inputs 0 -> 1 at edge N -> outputs unchanged through edge N+2 and updated at edge N+3.
REQ-025 With HAMMING_ERR_INJECT_EN, sweep all 16 inputs, each held 8 cycles -> outputs match the non-injected build every cycle; the internal syndrome equals the counter value at the decode stage.
REQ-026 Assert rst while a value is in the pipeline -> reset state on the next edge, and the in-flight value is never displayed.
